// File: rtl/jtag_port_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the JTAG debug port: TAP states,
// command opcodes and status word bit positions.
package jtag_port_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISEL   = 3'd1,
    ST_DSEL   = 3'd2,
    ST_ISHIFT = 3'd3,
    ST_DSHIFT = 3'd4,
    ST_UPDATE = 3'd5
  } jtag_state_e;

  localparam int unsigned CMD_NOP       = 0;
  localparam int unsigned CMD_SET_ADDR  = 1;
  localparam int unsigned CMD_READ      = 2;
  localparam int unsigned CMD_WRITE     = 3;
  localparam int unsigned CMD_SCAN      = 4;
  localparam int unsigned CMD_SPI       = 5;
  localparam int unsigned CMD_PAUSE     = 6;
  localparam int unsigned CMD_RUN       = 7;
  localparam int unsigned CMD_READ_INC  = 8;
  localparam int unsigned CMD_WRITE_INC = 9;

  localparam int unsigned STAT_BOOTED = 0;
  localparam int unsigned STAT_PAUSED = 1;
  localparam int unsigned STAT_BUSY   = 2;
  localparam int unsigned STAT_ERR    = 3;

endpackage

// File: rtl/jtag_pin_sync.sv
`timescale 1ns/1ps
// Pin synchroniser for TCK/TMS/TDI with registered TCK edge pulses.
// TMS/TDI get one extra flop so they stay aligned with the edge pulses.
module jtag_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic tck_i,
  input  logic tms_i,
  input  logic tdi_i,
  output logic tck_rise_o,
  output logic tck_fall_o,
  output logic tms_o,
  output logic tdi_o
);

  logic [SYNC_STAGES-1:0] tck_sq, tms_sq, tdi_sq;
  logic tck_prev_q, rise_q, fall_q, tms_q, tdi_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tck_sq     <= '0;
      tms_sq     <= '0;
      tdi_sq     <= '0;
      tck_prev_q <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      tms_q      <= 1'b0;
      tdi_q      <= 1'b0;
    end else begin
      tck_sq     <= {tck_sq[SYNC_STAGES-2:0], tck_i};
      tms_sq     <= {tms_sq[SYNC_STAGES-2:0], tms_i};
      tdi_sq     <= {tdi_sq[SYNC_STAGES-2:0], tdi_i};
      tck_prev_q <= tck_sq[SYNC_STAGES-1];
      rise_q     <= tck_sq[SYNC_STAGES-1] & ~tck_prev_q;
      fall_q     <= ~tck_sq[SYNC_STAGES-1] & tck_prev_q;
      tms_q      <= tms_sq[SYNC_STAGES-1];
      tdi_q      <= tdi_sq[SYNC_STAGES-1];
    end
  end

  assign tck_rise_o = rise_q;
  assign tck_fall_o = fall_q;
  assign tms_o      = tms_q;
  assign tdi_o      = tdi_q;

endmodule

// File: rtl/jtag_port_ctrl.sv
`timescale 1ns/1ps
// Debug port controller: IR/DR shift FSM clocked by oversampled TCK,
// executing debug commands onto a req/ack memory bus.
//   state  | meaning
//   IDLE   | waiting for a scan to start
//   ISEL   | choose IR scan (TMS=0) or go to DR select
//   DSEL   | choose DR scan (TMS=0) or back to idle
//   ISHIFT | shifting IR, status captured on entry
//   DSHIFT | shifting DR
//   UPDATE | command in IR executes once
module jtag_port_ctrl
  import jtag_port_pkg::*;
#(
  parameter int IR_WIDTH    = 8,
  parameter int DR_WIDTH    = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  jtag_tck,
  input  logic                  jtag_tms,
  input  logic                  jtag_tdi,
  output logic                  jtag_tdo,
  input  logic                  is_booted,
  input  logic                  is_paused,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DR_WIDTH-1:0]   mem_wdata,
  input  logic [DR_WIDTH-1:0]   mem_rdata,
  input  logic                  mem_ack,
  output logic                  en_scan_relay,
  output logic                  en_spi_relay,
  output logic                  req_pause,
  output logic                  req_run
);

  logic tck_rise, tck_fall, tms_s, tdi_s;

  jtag_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .rst        (rst),
    .tck_i      (jtag_tck),
    .tms_i      (jtag_tms),
    .tdi_i      (jtag_tdi),
    .tck_rise_o (tck_rise),
    .tck_fall_o (tck_fall),
    .tms_o      (tms_s),
    .tdi_o      (tdi_s)
  );

  jtag_state_e           state_q, state_d;
  logic [IR_WIDTH-1:0]   ir_q, ir_d, status_w;
  logic [DR_WIDTH-1:0]   dr_q, dr_d, wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic err_q, err_d, req_q, req_d, we_q, we_d, inc_q, inc_d;
  logic tdo_q, tdo_d, scan_q, scan_d, spi_q, spi_d;
  logic pause_q, pause_d, run_q, run_d, exec_q, exec_d;
  logic in_control, cmd_known, cmd_allowed;

  assign in_control = is_booted & is_paused;

  always_comb begin
    cmd_known   = 1'b1;
    cmd_allowed = in_control;
    case (ir_q)
      IR_WIDTH'(CMD_NOP):   cmd_allowed = 1'b1;
      IR_WIDTH'(CMD_PAUSE): cmd_allowed = is_booted;
      IR_WIDTH'(CMD_SET_ADDR), IR_WIDTH'(CMD_READ), IR_WIDTH'(CMD_WRITE),
      IR_WIDTH'(CMD_SCAN), IR_WIDTH'(CMD_SPI), IR_WIDTH'(CMD_RUN),
      IR_WIDTH'(CMD_READ_INC), IR_WIDTH'(CMD_WRITE_INC): cmd_allowed = in_control;
      default: begin
        cmd_known   = 1'b0;
        cmd_allowed = 1'b0;
      end
    endcase
    if (req_q && ir_q != IR_WIDTH'(CMD_NOP)) cmd_allowed = 1'b0;

    status_w              = '0;
    status_w[STAT_ERR]    = err_q;
    status_w[STAT_BUSY]   = req_q;
    status_w[STAT_PAUSED] = is_paused;
    status_w[STAT_BOOTED] = is_booted;
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    dr_d    = dr_q;
    addr_d  = addr_q;
    err_d   = err_q;
    req_d   = req_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    inc_d   = inc_q;
    tdo_d   = tdo_q;
    scan_d  = scan_q;
    spi_d   = spi_q;
    pause_d = 1'b0;
    run_d   = 1'b0;
    exec_d  = 1'b0;

    if (tck_rise) begin
      case (state_q)
        ST_IDLE: if (!tms_s) state_d = ST_ISEL;
        ST_ISEL: begin
          if (!tms_s) begin
            state_d = ST_ISHIFT;
            ir_d    = status_w;
            err_d   = 1'b0;
          end else begin
            state_d = ST_DSEL;
          end
        end
        ST_DSEL: state_d = tms_s ? ST_IDLE : ST_DSHIFT;
        ST_ISHIFT: begin
          ir_d = {ir_q[IR_WIDTH-2:0], tdi_s};
          if (tms_s) begin
            state_d = ST_UPDATE;
            exec_d  = 1'b1;
          end
        end
        ST_DSHIFT: begin
          dr_d = {dr_q[DR_WIDTH-2:0], tdi_s};
          if (tms_s) begin
            state_d = ST_UPDATE;
            exec_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (tck_fall) begin
      if (state_q == ST_ISHIFT)      tdo_d = ir_q[IR_WIDTH-1];
      else if (state_q == ST_DSHIFT) tdo_d = dr_q[DR_WIDTH-1];
      else                           tdo_d = 1'b0;
    end

    if (exec_q) begin
      if (!cmd_known || !cmd_allowed) begin
        err_d = 1'b1;
      end else begin
        scan_d = 1'b0;
        spi_d  = 1'b0;
        case (ir_q)
          IR_WIDTH'(CMD_SET_ADDR): addr_d = dr_q[ADDR_WIDTH-1:0];
          IR_WIDTH'(CMD_READ), IR_WIDTH'(CMD_READ_INC): begin
            req_d = 1'b1;
            we_d  = 1'b0;
            inc_d = (ir_q == IR_WIDTH'(CMD_READ_INC));
          end
          IR_WIDTH'(CMD_WRITE), IR_WIDTH'(CMD_WRITE_INC): begin
            req_d   = 1'b1;
            we_d    = 1'b1;
            wdata_d = dr_q;
            inc_d   = (ir_q == IR_WIDTH'(CMD_WRITE_INC));
          end
          IR_WIDTH'(CMD_SCAN):  scan_d  = 1'b1;
          IR_WIDTH'(CMD_SPI):   spi_d   = 1'b1;
          IR_WIDTH'(CMD_PAUSE): pause_d = 1'b1;
          IR_WIDTH'(CMD_RUN):   run_d   = 1'b1;
          default: ;
        endcase
      end
    end

    // Ack completion is applied last so it overrides a concurrent DR shift.
    if (mem_ack && req_q) begin
      req_d = 1'b0;
      if (!we_q) dr_d = mem_rdata;
      if (inc_q) addr_d = addr_q + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ir_q    <= '0;
      dr_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      inc_q   <= 1'b0;
      tdo_q   <= 1'b0;
      scan_q  <= 1'b0;
      spi_q   <= 1'b0;
      pause_q <= 1'b0;
      run_q   <= 1'b0;
      exec_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      dr_q    <= dr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      req_q   <= req_d;
      we_q    <= we_d;
      inc_q   <= inc_d;
      tdo_q   <= tdo_d;
      scan_q  <= scan_d;
      spi_q   <= spi_d;
      pause_q <= pause_d;
      run_q   <= run_d;
      exec_q  <= exec_d;
    end
  end

  assign jtag_tdo      = tdo_q;
  assign mem_req       = req_q;
  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign en_scan_relay = scan_q;
  assign en_spi_relay  = spi_q;
  assign req_pause     = pause_q;
  assign req_run       = run_q;

endmodule

// File: tb/tb_jtag_port_ctrl.sv
`timescale 1ns/1ps
// Bench for jtag_port_ctrl: drives JTAG scans from tasks, keeps a
// command-level model of the port and compares outputs every settled cycle.
module tb_jtag_port_ctrl;

  logic        clk;
  logic        rst;
  logic        jtag_tck, jtag_tms, jtag_tdi;
  logic        jtag_tdo;
  logic        is_booted, is_paused;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        en_scan_relay, en_spi_relay, req_pause, req_run;

  jtag_port_ctrl #(
    .IR_WIDTH(8), .DR_WIDTH(16), .ADDR_WIDTH(16), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst(rst),
    .jtag_tck(jtag_tck), .jtag_tms(jtag_tms), .jtag_tdi(jtag_tdi), .jtag_tdo(jtag_tdo),
    .is_booted(is_booted), .is_paused(is_paused),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .en_scan_relay(en_scan_relay), .en_spi_relay(en_spi_relay),
    .req_pause(req_pause), .req_run(req_run)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  // model of the port as seen by the debug host
  logic [7:0]  m_ir;
  logic [15:0] m_dr, m_addr, exp_addr, exp_wdata;
  logic        m_err, m_busy, m_scan, m_spi, exp_we, exp_inc;
  int          m_txns = 0, m_pauses = 0, m_runs = 0;
  int          dut_txns = 0, dut_pauses = 0, dut_runs = 0;
  logic        req_seen = 1'b0;
  logic        settled  = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ir = 8'h00; m_dr = 16'h0; m_addr = 16'h0;
    m_err = 1'b0; m_busy = 1'b0; m_scan = 1'b0; m_spi = 1'b0;
    exp_addr = 16'h0; exp_wdata = 16'h0; exp_we = 1'b0; exp_inc = 1'b0;
  endtask

  task automatic model_exec();
    bit ok;
    bit ctl;
    ctl = is_booted && is_paused;
    case (m_ir)
      8'h00:                               ok = 1'b1;
      8'h06:                               ok = is_booted;
      8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
      8'h07, 8'h08, 8'h09:                 ok = ctl;
      default:                             ok = 1'b0;
    endcase
    if (m_ir != 8'h00 && m_busy) ok = 1'b0;
    if (!ok) begin
      m_err = 1'b1;
    end else begin
      m_scan = (m_ir == 8'h04);
      m_spi  = (m_ir == 8'h05);
      if (m_ir == 8'h01) m_addr = m_dr;
      if (m_ir == 8'h06) m_pauses++;
      if (m_ir == 8'h07) m_runs++;
      if (m_ir inside {8'h02, 8'h03, 8'h08, 8'h09}) begin
        m_busy    = 1'b1;
        exp_we    = (m_ir == 8'h03 || m_ir == 8'h09);
        exp_inc   = (m_ir >= 8'h08);
        exp_addr  = m_addr;
        exp_wdata = m_dr;
        m_txns++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (req_pause) dut_pauses++;
      if (req_run)   dut_runs++;
      if (mem_req && !req_seen) dut_txns++;
      if (settled) begin
        check("scan_relay", en_scan_relay, m_scan);
        check("spi_relay", en_spi_relay, m_spi);
        check("mem_req", mem_req, m_busy);
        if (m_busy) begin
          check("mem_we", mem_we, exp_we);
          check("mem_addr", mem_addr, exp_addr);
          check("mem_wdata", mem_wdata, exp_wdata);
        end
      end
    end
    req_seen = mem_req;
  end

  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One TCK period: 10 clk low then 5 clk high; TDO sampled late in the low phase.
  task automatic tck_cycle(input logic t_ms, input logic t_di, output logic t_do);
    jtag_tms = t_ms;
    jtag_tdi = t_di;
    clk_n(5);
    jtag_tck = 1'b1;
    clk_n(5);
    jtag_tck = 1'b0;
    clk_n(5);
    t_do = jtag_tdo;
  endtask

  task automatic scan(input bit is_ir, input logic [15:0] din, output logic [15:0] dout);
    int n;
    logic b;
    logic [15:0] exp_out;
    n = is_ir ? 8 : 16;
    dout = 16'h0;
    tck_cycle(1'b0, 1'b0, b);
    if (is_ir) begin
      exp_out = {8'h00, 4'h0, m_err, m_busy, is_paused, is_booted};
      m_err = 1'b0;
    end else begin
      tck_cycle(1'b1, 1'b0, b);
      exp_out = m_dr;
    end
    tck_cycle(1'b0, 1'b0, b);
    dout[n-1] = b;
    for (int i = n - 1; i >= 0; i--) begin
      if (i == 0) settled = 1'b0;
      tck_cycle(i == 0, din[i], b);
      if (i > 0) dout[i-1] = b;
    end
    tck_cycle(1'b1, 1'b0, b);
    check(is_ir ? "ir_capture" : "dr_shift_out", dout, exp_out);
    if (is_ir) m_ir = din[7:0];
    else       m_dr = din;
    model_exec();
    clk_n(2);
    settled = 1'b1;
  endtask

  task automatic ir_scan(input logic [7:0] v, output logic [7:0] cap);
    logic [15:0] d;
    scan(1'b1, {8'h00, v}, d);
    cap = d[7:0];
  endtask

  task automatic dr_scan(input logic [15:0] v, output logic [15:0] dout);
    scan(1'b0, v, dout);
  endtask

  task automatic do_ack(input logic [15:0] rdata);
    settled = 1'b0;
    @(negedge clk);
    check("ack_req_high", mem_req, 1'b1);
    mem_rdata = rdata;
    mem_ack   = 1'b1;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = 16'h0;
    check("req_drop_after_ack", mem_req, 1'b0);
    if (!exp_we) m_dr = rdata;
    if (exp_inc) m_addr = m_addr + 16'h1;
    m_busy = 1'b0;
    clk_n(1);
    settled = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  cap;
    logic [15:0] dout;
    rst = 1'b1;
    jtag_tck = 1'b0; jtag_tms = 1'b1; jtag_tdi = 1'b0;
    is_booted = 1'b0; is_paused = 1'b0;
    mem_ack = 1'b0; mem_rdata = 16'h0;
    model_reset();
    clk_n(3);
    check("reset_ctrl_outs", {mem_req, mem_we, jtag_tdo, en_scan_relay, en_spi_relay,
                              req_pause, req_run}, 7'h00);
    check("reset_addr", mem_addr, 16'h0);
    check("reset_wdata", mem_wdata, 16'h0);
    rst = 1'b0;
    clk_n(5);
    settled = 1'b1;

    // SET_ADDR 0x1234, then WRITE 0xBEEF
    is_booted = 1'b1; is_paused = 1'b1;
    ir_scan(8'h01, cap);
    check("cap_first", cap, 8'h03);
    dr_scan(16'h1234, dout);
    check("no_req_after_set_addr", mem_req, 1'b0);
    ir_scan(8'h00, cap);
    dr_scan(16'hBEEF, dout);
    ir_scan(8'h03, cap);
    check("wr_req", mem_req, 1'b1);
    check("wr_we", mem_we, 1'b1);
    check("wr_addr", mem_addr, 16'h1234);
    check("wr_wdata", mem_wdata, 16'hBEEF);
    clk_n(4);
    do_ack(16'h0);

    // READ_INC at the top of the address space
    ir_scan(8'h01, cap);
    dr_scan(16'hFFFF, dout);
    ir_scan(8'h08, cap);
    check("rdinc_addr", mem_addr, 16'hFFFF);
    check("rdinc_we", mem_we, 1'b0);
    do_ack(16'hA5A5);
    ir_scan(8'h00, cap);
    dr_scan(16'h0000, dout);
    check("rdata_out", dout, 16'hA5A5);
    ir_scan(8'h02, cap);
    check("addr_wrapped", mem_addr, 16'h0000);
    do_ack(16'h1111);

    // precondition failure sets err, visible in the next capture only
    is_paused = 1'b0;
    ir_scan(8'h03, cap);
    check("rejected_no_req", mem_req, 1'b0);
    ir_scan(8'h00, cap);
    check("cap_err", cap, 8'h09);
    ir_scan(8'h00, cap);
    check("cap_err_cleared", cap, 8'h01);

    // control commands
    ir_scan(8'h06, cap);
    check("pause_pulses", dut_pauses, 1);
    is_paused = 1'b1;
    ir_scan(8'h07, cap);
    check("run_pulses", dut_runs, 1);
    ir_scan(8'h04, cap);
    check("scan_on", {en_scan_relay, en_spi_relay}, 2'b10);
    ir_scan(8'h05, cap);
    check("spi_on", {en_scan_relay, en_spi_relay}, 2'b01);
    ir_scan(8'h2A, cap);
    check("bad_op_keeps_relay", {en_scan_relay, en_spi_relay}, 2'b01);
    ir_scan(8'h00, cap);
    check("cap_bad_op_err", cap, 8'h0B);
    check("nop_clears", {en_scan_relay, en_spi_relay}, 2'b00);

    // second command while the first is still outstanding
    dr_scan(16'h5555, dout);
    ir_scan(8'h03, cap);
    ir_scan(8'h03, cap);
    check("cap_busy", cap, 8'h07);
    clk_n(20);
    check("single_txn", dut_txns, m_txns);
    do_ack(16'h0);
    ir_scan(8'h00, cap);
    check("cap_busy_reject_err", cap, 8'h0B);

    // reset in the middle of a transaction
    ir_scan(8'h02, cap);
    check("pre_reset_req", mem_req, 1'b1);
    settled = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check("rst_ctrl_outs", {mem_req, mem_we, jtag_tdo, en_scan_relay, en_spi_relay,
                            req_pause, req_run}, 7'h00);
    check("rst_addr", mem_addr, 16'h0);
    model_reset();
    clk_n(2);
    rst = 1'b0;
    clk_n(2);
    mem_rdata = 16'hDEAD;
    mem_ack = 1'b1;
    clk_n(1);
    mem_ack = 1'b0;
    mem_rdata = 16'h0;
    clk_n(2);
    check("stray_ack_no_req", mem_req, 1'b0);
    settled = 1'b1;
    dr_scan(16'h0000, dout);
    check("dr_after_reset", dout, 16'h0000);

    check("txn_count", dut_txns, m_txns);
    check("pause_count", dut_pauses, m_pauses);
    check("run_count", dut_runs, m_runs);
    settled = 1'b0;
    clk_n(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
